// File: rtl/add_rr_arbiter.sv
// Round-robin arbiter that shares one W-bit adder among NUM_REQ requesters and holds a registered result.
// Optional feature: define ADD_ARB_SAT_EN to saturate res_data when the carry-out is set.
module add_rr_arbiter #(
  parameter int W       = 8,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*W-1:0] req_a,
  input  logic [NUM_REQ*W-1:0] req_b,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [W-1:0]         res_data,
  output logic                 res_carry,
  output logic [ID_W-1:0]      res_id
);

  typedef enum logic {ST_EMPTY, ST_FULL} state_t;

  state_t          state_reg, state_next;
  logic [ID_W-1:0] rr_ptr_reg, rr_ptr_next;
  logic [ID_W-1:0] grant_idx;
  logic            grant_any;
  logic            can_accept;
  logic            handshake;
  logic [W-1:0]    a_arr [NUM_REQ];
  logic [W-1:0]    b_arr [NUM_REQ];
  logic [W-1:0]    a_sel, b_sel;
  logic [W:0]      sum;
  logic [W-1:0]    data_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign a_arr[gi] = req_a[gi*W +: W];
      assign b_arr[gi] = req_b[gi*W +: W];
      // Ready is forced low while reset is held, even though the state already reads empty.
      assign req_ready[gi] = !rst && grant_any && (grant_idx == ID_W'(gi)) && can_accept;
    end
  endgenerate

  // Scan from the farthest offset down so the nearest valid requester at or after rr_ptr wins.
  always_comb begin
    logic [ID_W-1:0] idx;
    idx       = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = rr_ptr_reg + ID_W'(k);
      if (req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = idx;
      end
    end
  end

  assign res_valid  = (state_reg == ST_FULL);
  assign can_accept = !res_valid || res_ready;
  assign handshake  = !rst && grant_any && can_accept;

  assign a_sel = a_arr[grant_idx];
  assign b_sel = b_arr[grant_idx];
  assign sum   = {1'b0, a_sel} + {1'b0, b_sel};

`ifdef ADD_ARB_SAT_EN
  assign data_next = sum[W] ? {W{1'b1}} : sum[W-1:0];
`else
  assign data_next = sum[W-1:0];
`endif

  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    if (handshake) begin
      rr_ptr_next = grant_idx + ID_W'(1);
    end
    case (state_reg)
      ST_EMPTY: if (handshake) state_next = ST_FULL;
      ST_FULL:  if (res_ready && !handshake) state_next = ST_EMPTY;
      default:  state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_EMPTY;
      rr_ptr_reg <= '0;
      res_data   <= '0;
      res_carry  <= 1'b0;
      res_id     <= '0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      if (handshake) begin
        res_data  <= data_next;
        res_carry <= sum[W];
        res_id    <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_add_rr_arbiter.sv
// Directed self-checking bench for add_rr_arbiter (4 requesters, 8-bit operands).
// Expectations follow ADD_ARB_SAT_EN when the bench is built with that macro.
module tb_add_rr_arbiter;
  localparam int W = 8;
  localparam int NUM_REQ = 4;
  localparam int ID_W = 2;

  logic                 clk;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*W-1:0] req_a;
  logic [NUM_REQ*W-1:0] req_b;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 res_valid;
  logic                 res_ready;
  logic [W-1:0]         res_data;
  logic                 res_carry;
  logic [ID_W-1:0]      res_id;

  int checks = 0;
  int failures = 0;

  add_rr_arbiter #(.W(W), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_carry(res_carry), .res_id(res_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_res(input string tag, input logic [W-1:0] d, input logic c, input logic [ID_W-1:0] id);
    chk({tag, "_valid"}, 32'(res_valid), 32'd1);
    chk({tag, "_data"},  32'(res_data),  32'(d));
    chk({tag, "_carry"}, 32'(res_carry), 32'(c));
    chk({tag, "_id"},    32'(res_id),    32'(id));
  endtask

  initial begin
    logic [W-1:0] ovf_exp;
`ifdef ADD_ARB_SAT_EN
    ovf_exp = 8'hFF;
`else
    ovf_exp = 8'h10;
`endif
    // Reset with every requester asking
    rst = 1'b1;
    res_ready = 1'b1;
    req_valid = 4'b1111;
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < NUM_REQ; i++) set_op(i, 8'(i), 8'h10);
    #12;
    chk("rst_ready", 32'(req_ready), 32'b0000);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_data",  32'(res_data),  32'd0);
    chk("rst_carry", 32'(res_carry), 32'd0);
    chk("rst_id",    32'(res_id),    32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("c0_ready", 32'(req_ready), 32'b0001);
    $display("reset released, req0 granted");

    // Round robin 0,1,2,3,0
    tick();
    chk_res("rr0", 8'h10, 1'b0, 2'd0);
    chk("rr0_ready", 32'(req_ready), 32'b0010);
    $display("rr: id=%0d data=%0h", res_id, res_data);
    tick();
    chk_res("rr1", 8'h11, 1'b0, 2'd1);
    chk("rr1_ready", 32'(req_ready), 32'b0100);
    $display("rr: id=%0d data=%0h", res_id, res_data);
    tick();
    chk_res("rr2", 8'h12, 1'b0, 2'd2);
    chk("rr2_ready", 32'(req_ready), 32'b1000);
    $display("rr: id=%0d data=%0h", res_id, res_data);
    tick();
    chk_res("rr3", 8'h13, 1'b0, 2'd3);
    chk("rr3_ready", 32'(req_ready), 32'b0001);
    $display("rr: id=%0d data=%0h", res_id, res_data);
    tick();
    chk_res("rr4", 8'h10, 1'b0, 2'd0);
    $display("rr: id=%0d data=%0h", res_id, res_data);

    // Backpressure: lone requester 2, then stall
    req_valid = 4'b0100;
    set_op(2, 8'h7F, 8'h01);
    #1;
    chk("bp_single_ready", 32'(req_ready), 32'b0100);
    tick();
    chk_res("bp_load", 8'h80, 1'b0, 2'd2);
    res_ready = 1'b0;
    req_valid = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_stall_ready", 32'(req_ready), 32'b0000);
      tick();
      chk_res("bp_hold", 8'h80, 1'b0, 2'd2);
      $display("stall cycle %0d: data=%0h id=%0d", c, res_data, res_id);
    end
    res_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(req_ready), 32'b1000);
    tick();
    chk_res("bp_next", 8'h13, 1'b0, 2'd3);
    $display("release: id=%0d data=%0h", res_id, res_data);

    // Overflow on requester 1
    req_valid = 4'b0010;
    set_op(1, 8'hF0, 8'h20);
    #1;
    chk("ovf_ready", 32'(req_ready), 32'b0010);
    tick();
    chk_res("ovf", ovf_exp, 1'b1, 2'd1);
    $display("overflow: data=%0h carry=%0d", res_data, res_carry);

    // Move rr_ptr to 1, then skip with 1001
    req_valid = 4'b0001;
    #1;
    chk("skip_pre_ready", 32'(req_ready), 32'b0001);
    tick();
    chk_res("skip_pre", 8'h10, 1'b0, 2'd0);
    req_valid = 4'b1001;
    #1;
    chk("skip_ready", 32'(req_ready), 32'b1000);
    tick();
    chk_res("skip", 8'h13, 1'b0, 2'd3);
    $display("skip: id=%0d", res_id);

    // No requesters: drain to empty, pointer holds at 0
    req_valid = 4'b0000;
    #1;
    chk("idle_ready", 32'(req_ready), 32'b0000);
    tick();
    chk("idle_valid", 32'(res_valid), 32'd0);
    tick();
    chk("idle_valid2", 32'(res_valid), 32'd0);
    req_valid = 4'b1111;
    #1;
    chk("ptr_hold_ready", 32'(req_ready), 32'b0001);
    tick();
    chk_res("ptr_hold", 8'h10, 1'b0, 2'd0);
    $display("after idle: id=%0d", res_id);

    // Async reset while holding a result
    res_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(res_valid), 32'd0);
    chk("arst_data",  32'(res_data),  32'd0);
    chk("arst_id",    32'(res_id),    32'd0);
    chk("arst_ready", 32'(req_ready), 32'b0000);
    $display("async reset: res_valid=%0d", res_valid);
    tick();
    chk("arst_hold_valid", 32'(res_valid), 32'd0);
    chk("arst_hold_ready", 32'(req_ready), 32'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
